// File: rtl/reg8_serializer.sv
// reg8_serializer: accepts one WIDTH-bit word via valid/ready and shifts it
// out one bit per enabled clock with first/last framing, a done pulse and an
// optional idle gap between words. Shares clk_ena/sclr_n conventions with the
// datapath holding registers.
module reg8_serializer #(
  parameter int   WIDTH      = 8,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter int   GAP_CYCLES = 1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_ena,
  input  logic             sclr_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_first,
  output logic             ser_last,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam int GW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             ser_out_q, ser_out_d;
  logic             ser_valid_q, ser_valid_d;
  logic             ser_first_q, ser_first_d;
  logic             ser_last_q, ser_last_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] rot;

  assign load_ready = (state_q == IDLE) && rst_n;
  assign ser_out    = ser_out_q;
  assign ser_valid  = ser_valid_q;
  assign ser_first  = ser_first_q;
  assign ser_last   = ser_last_q;
  assign busy       = busy_q;
  assign done       = done_q;

  // Next-state and registered-output computation; everything holds when clk_ena=0.
  // The shift register rotates rather than shifts so every stored bit stays live;
  // it is cleared when the word completes, so the wrapped bits are never observed.
  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    cnt_d       = cnt_q;
    gap_d       = gap_q;
    ser_out_d   = ser_out_q;
    ser_valid_d = ser_valid_q;
    ser_first_d = ser_first_q;
    ser_last_d  = ser_last_q;
    busy_d      = busy_q;
    done_d      = done_q;
    rot         = MSB_FIRST ? {sreg_q[WIDTH-2:0], sreg_q[WIDTH-1]}
                            : {sreg_q[0], sreg_q[WIDTH-1:1]};
    if (clk_ena) begin
      if (!sclr_n) begin
        state_d     = IDLE;
        sreg_d      = '0;
        cnt_d       = '0;
        gap_d       = '0;
        ser_out_d   = IDLE_LEVEL;
        ser_valid_d = 1'b0;
        ser_first_d = 1'b0;
        ser_last_d  = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            done_d = 1'b0;
            if (load_valid) begin
              state_d     = SHIFT;
              sreg_d      = data_in;
              cnt_d       = '0;
              ser_out_d   = MSB_FIRST ? data_in[WIDTH-1] : data_in[0];
              ser_valid_d = 1'b1;
              ser_first_d = 1'b1;
              ser_last_d  = 1'b0;
              busy_d      = 1'b1;
            end
          end
          SHIFT: begin
            if (cnt_q == CW'(WIDTH - 1)) begin
              done_d      = 1'b1;
              ser_valid_d = 1'b0;
              ser_first_d = 1'b0;
              ser_last_d  = 1'b0;
              ser_out_d   = IDLE_LEVEL;
              sreg_d      = '0;
              cnt_d       = '0;
              gap_d       = '0;
              if (GAP_CYCLES > 0) begin
                state_d = GAP;
                busy_d  = 1'b1;
              end else begin
                state_d = IDLE;
                busy_d  = 1'b0;
              end
            end else begin
              sreg_d      = rot;
              cnt_d       = cnt_q + 1'b1;
              ser_out_d   = MSB_FIRST ? rot[WIDTH-1] : rot[0];
              ser_first_d = 1'b0;
              ser_last_d  = (cnt_q == CW'(WIDTH - 2));
            end
          end
          GAP: begin
            done_d = 1'b0;
            if (gap_q == GW'(GAP_CYCLES - 1)) begin
              state_d = IDLE;
              busy_d  = 1'b0;
              gap_d   = '0;
            end else begin
              gap_d = gap_q + 1'b1;
            end
          end
          default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        endcase
      end
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sreg_q      <= '0;
      cnt_q       <= '0;
      gap_q       <= '0;
      ser_out_q   <= IDLE_LEVEL;
      ser_valid_q <= 1'b0;
      ser_first_q <= 1'b0;
      ser_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      ser_out_q   <= ser_out_d;
      ser_valid_q <= ser_valid_d;
      ser_first_q <= ser_first_d;
      ser_last_q  <= ser_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_reg8_serializer.sv
// Testbench for reg8_serializer: two instances (default parameters, and
// LSB-first / no gap / idle-high) driven with shared directed and random
// stimulus, compared every cycle against a word-position reference model.
module tb_reg8_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n, clk_ena, sclr_n, load_valid;
  logic [W-1:0] data_in;
  logic         lr0, so0, sv0, sf0, sl0, b0, d0;
  logic         lr1, so1, sv1, sf1, sl1, b1, d1;

  int total = 0;
  int bad   = 0;

  // Model state: t = 0 idle, 1..W bit t on the wire, W+1.. trailing cycles.
  int           t[2];
  logic [W-1:0] word[2];

  always #5 clk = ~clk;

  reg8_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .GAP_CYCLES(1), .IDLE_LEVEL(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .clk_ena(clk_ena), .sclr_n(sclr_n),
    .data_in(data_in), .load_valid(load_valid), .load_ready(lr0),
    .ser_out(so0), .ser_valid(sv0), .ser_first(sf0), .ser_last(sl0),
    .busy(b0), .done(d0)
  );

  reg8_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .GAP_CYCLES(0), .IDLE_LEVEL(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .clk_ena(clk_ena), .sclr_n(sclr_n),
    .data_in(data_in), .load_valid(load_valid), .load_ready(lr1),
    .ser_out(so1), .ser_valid(sv1), .ser_first(sf1), .ser_last(sl1),
    .busy(b1), .done(d1)
  );

  function automatic int gapc(int i);
    return (i == 0) ? 1 : 0;
  endfunction

  function automatic logic msb(int i);
    return (i == 0);
  endfunction

  function automatic logic idl(int i);
    return (i == 1);
  endfunction

  function automatic logic mbusy(int i);
    return (t[i] >= 1) && (t[i] <= W + gapc(i));
  endfunction

  // Expected {load_ready, ser_out, ser_valid, ser_first, ser_last, busy, done}.
  function automatic logic [6:0] expv(int i);
    int   tt;
    logic v, b;
    tt = t[i];
    v  = (tt >= 1) && (tt <= W);
    if (v) b = msb(i) ? word[i][W - tt] : word[i][tt - 1];
    else   b = idl(i);
    return {rst_n && !mbusy(i), b, v, tt == 1, tt == W, mbusy(i), tt == W + 1};
  endfunction

  function automatic logic [6:0] obs(int i);
    if (i == 0) return {lr0, so0, sv0, sf0, sl0, b0, d0};
    return {lr1, so1, sv1, sf1, sl1, b1, d1};
  endfunction

  // One enabled edge of the model, using the inputs present at that edge.
  function automatic void model_edge(int i);
    int n;
    if (!clk_ena) return;
    if (!sclr_n) begin
      t[i] = 0;
      word[i] = '0;
    end else if (!mbusy(i) && load_valid) begin
      t[i] = 1;
      word[i] = data_in;
    end else if (t[i] > 0) begin
      n = t[i] + 1;
      if (n > W + 1 && n > W + gapc(i)) n = 0;
      t[i] = n;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("u0_outs", 32'(obs(0)), 32'(expv(0)));
    chk("u1_outs", 32'(obs(1)), 32'(expv(1)));
  endtask

  // Drive inputs at the falling edge, advance one rising edge, check at the next falling edge.
  task automatic cyc(input logic v, input logic [W-1:0] d, input logic ena, input logic sclr);
    load_valid = v;
    data_in    = d;
    clk_ena    = ena;
    sclr_n     = sclr;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (rst_n) model_edge(i);
      else begin t[i] = 0; word[i] = '0; end
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin t[i] = 0; word[i] = '0; end
    #1 check_all();
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
  endtask

  initial begin
    int lat;
    rst_n = 1'b0; clk_ena = 1'b1; sclr_n = 1'b1; load_valid = 1'b0; data_in = '0;
    for (int i = 0; i < 2; i++) begin t[i] = 0; word[i] = '0; end
    @(negedge clk);
    check_all();
    chk("ready_in_reset", 32'(lr0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_all();

    // 0xA5: bits on cycles 1..8 after accept, done on cycle 9.
    cyc(1'b1, 8'hA5, 1'b1, 1'b1);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b1);
      if (d0 && lat == 0) lat = k + 1;
    end
    chk("done_cycle", 32'(lat), 32'(W + 1));

    // load_valid held high: 0x3C then 0xC3.
    for (int k = 0; k < 5; k++)  cyc(1'b1, 8'h3C, 1'b1, 1'b1);
    for (int k = 0; k < 25; k++) cyc(1'b1, 8'hC3, 1'b1, 1'b1);
    for (int k = 0; k < 12; k++) cyc(1'b0, 8'h00, 1'b1, 1'b1);

    // 0xF0 with clk_ena dropped for 3 cycles after bit 2.
    cyc(1'b1, 8'hF0, 1'b1, 1'b1);
    cyc(1'b0, 8'h00, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) cyc(1'b1, 8'h55, 1'b0, 1'b1);
    for (int k = 0; k < 10; k++) cyc(1'b0, 8'h00, 1'b1, 1'b1);

    // 0xFF with synchronous clear at bit 4 (also competing with a load).
    cyc(1'b1, 8'hFF, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) cyc(1'b0, 8'h00, 1'b1, 1'b1);
    cyc(1'b1, 8'h12, 1'b1, 1'b0);
    chk("sclr_ready", 32'(lr0), 32'd1);
    chk("sclr_nodone", 32'({d0, d1}), 32'd0);
    for (int k = 0; k < 3; k++) cyc(1'b0, 8'h00, 1'b1, 1'b1);

    // Asynchronous reset mid-word, then 0x81.
    cyc(1'b1, 8'h5A, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) cyc(1'b0, 8'h00, 1'b1, 1'b1);
    async_reset();
    cyc(1'b1, 8'h81, 1'b1, 1'b1);
    for (int k = 0; k < 12; k++) cyc(1'b0, 8'h00, 1'b1, 1'b1);

    // Back-to-back 0x01 then 0x80 with load_valid held high.
    for (int k = 0; k < 3; k++)  cyc(1'b1, 8'h01, 1'b1, 1'b1);
    for (int k = 0; k < 22; k++) cyc(1'b1, 8'h80, 1'b1, 1'b1);

    // Random traffic.
    for (int k = 0; k < 600; k++) begin
      cyc(($urandom % 4) != 0, W'($urandom), ($urandom % 8) != 0, ($urandom % 40) != 0);
      if (($urandom % 97) == 0) async_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
